branch_predictor: RTL and testbench

//  Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.

---
 rtl/branch_predictor_if.sv | 32 +++
 rtl/branch_predictor.sv | 122 ++++++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side training bus of the branch target buffer.
// master: the CPU pipeline driving PCs and resolved branches.
// slave: the predictor returning the prediction and the statistics.
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
);
    logic [ADDR_W-1:0] pc_i;
    logic              hit_o;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_mispred_i;
    logic              flush_i;
    logic [STAT_W-1:0] upd_cnt_o;
    logic [STAT_W-1:0] mispred_cnt_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_mispred_i, flush_i,
        input  hit_o, pred_taken_o, pred_target_o, upd_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_mispred_i, flush_i,
        output hit_o, pred_taken_o, pred_target_o, upd_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational from the fetch PC; training happens on
// the clock edge from the resolved branch in EX. Also keeps saturating
// counts of updates and mispredictions.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_WT - CTR_ONE;
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];
    logic [CTR_W-1:0]  ctr_d    [ENTRIES];

    logic [STAT_W-1:0] upd_cnt_q, upd_cnt_d;
    logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]  lk_idx, upd_idx;
    logic [TAG_W-1:0]  lk_tag, upd_tag;
    logic              lk_hit, lk_taken, upd_hit;

    assign lk_idx  = bp.pc_i[IDX_W+1:2];
    assign lk_tag  = bp.pc_i[ADDR_W-1:IDX_W+2];
    assign upd_idx = bp.upd_pc_i[IDX_W+1:2];
    assign upd_tag = bp.upd_pc_i[ADDR_W-1:IDX_W+2];

    // Combinational prediction straight from the stored table (no bypass of a same-cycle update)
    always_comb begin
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][CTR_W-1];
    end

    assign bp.hit_o         = lk_hit;
    assign bp.pred_taken_o  = lk_taken;
    assign bp.pred_target_o = lk_taken ? target_q[lk_idx] : bp.pc_i + ADDR_W'(4);
    assign bp.upd_cnt_o     = upd_cnt_q;
    assign bp.mispred_cnt_o = mispred_cnt_q;

    // Next table and statistics state: train on the resolved branch, flush wins over training
    always_comb begin
        valid_d       = valid_q;
        tag_d         = tag_q;
        target_d      = target_q;
        ctr_d         = ctr_q;
        upd_cnt_d     = upd_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

        if (bp.upd_valid_i && !bp.flush_i) begin
            if (upd_hit) begin
                if (bp.upd_taken_i) begin
                    target_d[upd_idx] = bp.upd_target_i;
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_ONE;
                    end
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_ONE;
                end
            end else if (bp.upd_taken_i) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bp.upd_target_i;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end

        if (bp.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end

        if (bp.upd_valid_i) begin
            if (upd_cnt_q != STAT_MAX) begin
                upd_cnt_d = upd_cnt_q + STAT_ONE;
            end
            if (bp.upd_mispred_i && (mispred_cnt_q != STAT_MAX)) begin
                mispred_cnt_d = mispred_cnt_q + STAT_ONE;
            end
        end
    end

    // State registers; reset empties the table and leaves every counter weakly not-taken
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            upd_cnt_q     <= upd_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16, CTR_W=2, STAT_W=4).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_W(32), .STAT_W(4)) bp_if ();

    branch_predictor #(
        .ADDR_W(32), .ENTRIES(16), .CTR_W(2), .STAT_W(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bp   (bp_if.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        umis;
        logic        fl;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    typedef struct {
        int          id;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic [31:0] pc, logic uv, logic [31:0] upc, logic ut,
                                logic [31:0] utgt, logic umis, logic fl,
                                logic eh, logic et, logic [31:0] etgt);
        vec_t v;
        v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.umis = umis; v.fl = fl; v.eh = eh; v.et = et; v.etgt = etgt;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        bp_if.upd_valid_i   = 1'b0;
        bp_if.upd_pc_i      = '0;
        bp_if.upd_taken_i   = 1'b0;
        bp_if.upd_target_i  = '0;
        bp_if.upd_mispred_i = 1'b0;
        bp_if.flush_i       = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        bp_if.pc_i          = v.pc;
        bp_if.upd_valid_i   = v.uv;
        bp_if.upd_pc_i      = v.upc;
        bp_if.upd_taken_i   = v.ut;
        bp_if.upd_target_i  = v.utgt;
        bp_if.upd_mispred_i = v.umis;
        bp_if.flush_i       = v.fl;
        e.id = id; e.eh = v.eh; e.et = v.et; e.etgt = v.etgt;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        checks--;
        e = sb.pop_front();
        checkValue($sformatf("vec%0d hit", e.id), {31'b0, bp_if.hit_o}, {31'b0, e.eh});
        checkValue($sformatf("vec%0d taken", e.id), {31'b0, bp_if.pred_taken_o}, {31'b0, e.et});
        checkValue($sformatf("vec%0d target", e.id), bp_if.pred_target_o, e.etgt);
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(i, vecs[i]);
            checkOutput();
        end
        @(posedge clk);
        #1;
        driveIdle();
    endtask

    initial begin
        // Reset, allocate-on-taken, same-cycle update invisible until next cycle
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0, 32'h44));   // 0
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,  0, 0, 1, 1, 32'h80));   // 1
        // Counter walk down to strong-NT, up to saturation, then back
        vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,  0, 0, 1, 1, 32'h80));   // 2
        vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,  1, 0, 1, 0, 32'h44));   // 3
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,  0, 0, 1, 0, 32'h44));   // 4
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h80, 0, 0, 1, 0, 32'h44));   // 5
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h80, 0, 0, 1, 0, 32'h44));   // 6
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h80, 0, 0, 1, 1, 32'h80));   // 7
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h80, 0, 0, 1, 1, 32'h80));   // 8
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h80, 0, 0, 1, 1, 32'h80));   // 9
        vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,  1, 0, 1, 1, 32'h80));   // 10
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,  0, 0, 1, 1, 32'h80));   // 11
        vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,  0, 0, 1, 1, 32'h80));   // 12
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,  0, 0, 1, 0, 32'h44));   // 13
        // Alias at index 0 replaces the entry; not-taken miss leaves it alone
        vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h100, 1, 0, 0, 0, 32'h84));  // 14
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 32'h44));   // 15
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,  0, 0, 1, 1, 32'h100));  // 16
        vecs.push_back(mk(32'h80, 1, 32'h1000, 0, 32'h0, 0, 0, 1, 1, 32'h100)); // 17
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,  0, 0, 1, 1, 32'h100));  // 18
        vecs.push_back(mk(32'h44, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 32'h48));   // 19
        // Same-cycle update on a hit, then target retrain on a taken hit
        vecs.push_back(mk(32'h80, 1, 32'h80, 0, 32'h0,  0, 0, 1, 1, 32'h100));  // 20
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,  0, 0, 1, 0, 32'h84));   // 21
        vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h200, 0, 0, 1, 0, 32'h84));  // 22
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,  0, 0, 1, 1, 32'h200));  // 23
        // pc+4 wraps; low PC bits do not affect index or tag
        vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0)); // 24
        vecs.push_back(mk(32'h82, 0, 32'h0,  0, 32'h0,  0, 0, 1, 1, 32'h200));  // 25
        // Flush beats a simultaneous taken update; everything misses afterwards
        vecs.push_back(mk(32'h80, 1, 32'h44, 1, 32'h300, 0, 1, 1, 1, 32'h200)); // 26
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 32'h84));   // 27
        vecs.push_back(mk(32'h44, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 32'h48));   // 28
        vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h400, 0, 0, 0, 0, 32'h84));  // 29
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,  0, 0, 1, 1, 32'h400));  // 30

        bp_if.pc_i = 32'h40;
        driveIdle();
        repeat (2) @(negedge clk);
        checkValue("reset upd_cnt", {28'b0, bp_if.upd_cnt_o}, 32'd0);
        checkValue("reset mispred_cnt", {28'b0, bp_if.mispred_cnt_o}, 32'd0);
        rst_n = 1'b1;

        runVectors(0, 25);
        checkValue("upd_cnt after training", {28'b0, bp_if.upd_cnt_o}, 32'd14);
        checkValue("mispred_cnt after training", {28'b0, bp_if.mispred_cnt_o}, 32'd3);

        runVectors(26, 30);
        checkValue("upd_cnt after flush", {28'b0, bp_if.upd_cnt_o}, 32'd15);
        checkValue("mispred_cnt after flush", {28'b0, bp_if.mispred_cnt_o}, 32'd3);

        // Asynchronous reset mid-cycle with a live hit on pc 0x80
        bp_if.pc_i = 32'h80;
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async reset hit", {31'b0, bp_if.hit_o}, 32'd0);
        checkValue("async reset taken", {31'b0, bp_if.pred_taken_o}, 32'd0);
        checkValue("async reset target", bp_if.pred_target_o, 32'h84);
        checkValue("async reset upd_cnt", {28'b0, bp_if.upd_cnt_o}, 32'd0);
        checkValue("async reset mispred_cnt", {28'b0, bp_if.mispred_cnt_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Twenty mispredicted not-taken misses drive both statistics to all-ones
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bp_if.upd_valid_i   = 1'b1;
            bp_if.upd_pc_i      = 32'h1000;
            bp_if.upd_taken_i   = 1'b0;
            bp_if.upd_mispred_i = 1'b1;
            if (i == 10) begin
                checkValue("upd_cnt mid-run", {28'b0, bp_if.upd_cnt_o}, 32'd10);
            end
        end
        @(posedge clk);
        #1;
        driveIdle();
        checkValue("upd_cnt saturated", {28'b0, bp_if.upd_cnt_o}, 32'd15);
        checkValue("mispred_cnt saturated", {28'b0, bp_if.mispred_cnt_o}, 32'd15);
        checkValue("lookup after reset", {31'b0, bp_if.hit_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
